// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: issues sequential word reads to a 1-cycle-latency
// instruction memory and feeds decode through a 2-entry prefetch queue.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_code,
    input  logic        inst_ready,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic        inflight;
    logic [1:0]  count;
    logic [31:0] head_pc, head_code;
    logic [31:0] tail_pc, tail_code;

    logic        pop;
    logic        push;
    logic        room;

    // 33-bit sum so addresses near the top of the 32-bit space cannot wrap into range
    function automatic logic legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (({1'b0, pc} + 33'd3) < 33'(MEM_BYTES));
    endfunction

    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != 2'd0);
    assign inst_pc    = head_pc;
    assign inst_code  = head_code;

    assign pop  = inst_valid && inst_ready;
    assign push = inflight;
    assign room = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    assign imem_rd_en = (state == RUN) && enable && !redirect_valid && legal(fetch_pc) && room;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight_pc <= 32'h0;
            inflight    <= 1'b0;
            count       <= 2'd0;
            head_pc     <= 32'h0;
            head_code   <= 32'h0;
            tail_pc     <= 32'h0;
            tail_code   <= 32'h0;
            fault       <= 1'b0;
        end else if (state == IDLE) begin
            state <= RUN;
        end else if (redirect_valid) begin
            // Flush: clearing inflight makes the response arriving next cycle be dropped
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            count    <= 2'd0;
            if (legal(redirect_pc)) begin
                state <= RUN;
                fault <= 1'b0;
            end else begin
                state <= FAULT;
                fault <= 1'b1;
            end
        end else begin
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
            if (state == RUN && enable && !legal(fetch_pc)) begin
                state <= FAULT;
                fault <= 1'b1;
            end

            // Head register always holds the oldest entry; tail is used only at count 2
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd1) begin
                        head_pc   <= inflight_pc;
                        head_code <= imem_rdata;
                    end else begin
                        head_pc   <= tail_pc;
                        head_code <= tail_code;
                        tail_pc   <= inflight_pc;
                        tail_code <= imem_rdata;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc   <= inflight_pc;
                        head_code <= imem_rdata;
                    end else begin
                        tail_pc   <= inflight_pc;
                        tail_code <= imem_rdata;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc   <= tail_pc;
                    head_code <= tail_code;
                    count     <= count - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed latency/backpressure/redirect/fault/reset
// steps followed by randomized traffic checked against an instruction-stream model.
module tb_fetch_sequencer;

    localparam int MEM_BYTES = 44;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_code;
    logic        fault;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [16];

    always #5 clock = ~clock;

    fetch_sequencer #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .imem_addr(imem_addr),
        .imem_rd_en(imem_rd_en),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_pc(inst_pc),
        .inst_code(inst_code),
        .inst_ready(inst_ready),
        .fault(fault)
    );

    // Memory answers one cycle after a request; garbage otherwise so stray captures show up
    always @(posedge clock) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr[5:2]];
        else            imem_rdata <= 32'hDEAD_BEEF;
    end

    function automatic bit legal_pc(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && ((64'(pc) + 64'd3) < 64'(MEM_BYTES));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advances one cycle, drives this cycle's inputs, and returns once outputs settle
    task automatic applyStimulus(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        enable         = en;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic doReset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          pops;
        logic        en, rdy, rv;
        logic [31:0] rpc;
        logic        prev_hold, prev_rv;
        logic [31:0] prev_pc, prev_code, prev_rpc;

        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h0094_0333;
        mem[1] = 32'h4139_03b3;
        mem[8] = 32'h0020_a533;

        #2;
        checkOutput("reset_addr", imem_addr, 32'h0);
        checkBit("reset_rd_en", imem_rd_en, 1'b0);
        checkBit("reset_valid", inst_valid, 1'b0);
        checkOutput("reset_pc", inst_pc, 32'h0);
        checkOutput("reset_code", inst_code, 32'h0);
        checkBit("reset_fault", fault, 1'b0);

        // Startup latency and streaming
        doReset();
        applyStimulus(1, 1, 0, 0);
        checkBit("start_c1_rd_en", imem_rd_en, 1'b1);
        checkOutput("start_c1_addr", imem_addr, 32'h0);
        applyStimulus(1, 1, 0, 0);
        checkBit("start_c2_valid", inst_valid, 1'b0);
        checkOutput("start_c2_addr", imem_addr, 32'h4);
        applyStimulus(1, 1, 0, 0);
        checkBit("start_c3_valid", inst_valid, 1'b1);
        checkOutput("start_c3_pc", inst_pc, 32'h0);
        checkOutput("start_c3_code", inst_code, 32'h0094_0333);
        applyStimulus(1, 1, 0, 0);
        checkOutput("start_c4_pc", inst_pc, 32'h4);
        checkOutput("start_c4_code", inst_code, 32'h4139_03b3);
        applyStimulus(1, 1, 0, 0);
        checkBit("start_c5_valid", inst_valid, 1'b1);
        checkOutput("start_c5_pc", inst_pc, 32'h8);
        checkOutput("start_c5_code", inst_code, mem[2]);

        // Backpressure fills the queue, then drains in order
        doReset();
        for (int c = 1; c <= 4; c++) applyStimulus(1, 0, 0, 0);
        checkBit("bp_full_rd_en", imem_rd_en, 1'b0);
        checkBit("bp_full_valid", inst_valid, 1'b1);
        checkOutput("bp_full_pc", inst_pc, 32'h0);
        checkOutput("bp_full_addr", imem_addr, 32'h8);
        applyStimulus(1, 1, 0, 0);
        checkOutput("bp_drain_pc0", inst_pc, 32'h0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("bp_drain_pc4", inst_pc, 32'h4);
        applyStimulus(1, 1, 0, 0);
        checkBit("bp_drain_valid8", inst_valid, 1'b1);
        checkOutput("bp_drain_pc8", inst_pc, 32'h8);

        // Redirect while the fetch of 0x8 is outstanding
        doReset();
        for (int c = 1; c <= 3; c++) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 1, 32'h20);
        checkOutput("redir_inflight_addr", imem_addr, 32'hC);
        checkBit("redir_cycle_rd_en", imem_rd_en, 1'b0);
        applyStimulus(1, 1, 0, 0);
        checkBit("redir_c1_rd_en", imem_rd_en, 1'b1);
        checkOutput("redir_c1_addr", imem_addr, 32'h20);
        checkBit("redir_c1_valid", inst_valid, 1'b0);
        applyStimulus(1, 1, 0, 0);
        checkBit("redir_c2_valid", inst_valid, 1'b0);
        applyStimulus(1, 1, 0, 0);
        checkBit("redir_c3_valid", inst_valid, 1'b1);
        checkOutput("redir_c3_pc", inst_pc, 32'h20);
        checkOutput("redir_c3_code", inst_code, 32'h0020_a533);
        applyStimulus(1, 1, 0, 0);
        checkOutput("redir_c4_pc", inst_pc, 32'h24);

        // Misaligned redirect faults; a legal redirect recovers
        applyStimulus(1, 1, 1, 32'h22);
        applyStimulus(1, 1, 0, 0);
        checkBit("misalign_fault", fault, 1'b1);
        checkBit("misalign_rd_en", imem_rd_en, 1'b0);
        checkBit("misalign_valid", inst_valid, 1'b0);
        applyStimulus(1, 1, 0, 0);
        checkBit("misalign_valid_later", inst_valid, 1'b0);
        checkOutput("misalign_addr", imem_addr, 32'h22);
        applyStimulus(1, 1, 1, 32'h0);

        // Sequential run to the end of a 44-byte memory
        exp_pc = 32'h0;
        pops   = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1, 1, 0, 0);
            if (c == 0) begin
                checkBit("recover_fault", fault, 1'b0);
                checkBit("recover_rd_en", imem_rd_en, 1'b1);
                checkOutput("recover_addr", imem_addr, 32'h0);
            end
            checkBit("seq_issue_legal", imem_rd_en && !legal_pc(imem_addr), 1'b0);
            if (inst_valid) begin
                checkOutput("seq_pc", inst_pc, exp_pc);
                checkOutput("seq_code", inst_code, mem[exp_pc[5:2]]);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        checkOutput("seq_count", 32'(pops), 32'd11);
        checkBit("seq_end_fault", fault, 1'b1);
        checkOutput("seq_end_addr", imem_addr, 32'h2C);

        // Asynchronous reset with a full queue, with a request pending, and while faulted
        doReset();
        for (int c = 1; c <= 4; c++) applyStimulus(1, 0, 0, 0);
        checkBit("full_before_reset", inst_valid, 1'b1);
        #1 reset = 1'b1;
        #1;
        checkBit("async_valid", inst_valid, 1'b0);
        checkOutput("async_addr", imem_addr, 32'h0);
        checkOutput("async_pc", inst_pc, 32'h0);
        checkBit("async_fault", fault, 1'b0);
        doReset();
        applyStimulus(1, 1, 0, 0);
        checkBit("pre_reset_rd_en", imem_rd_en, 1'b1);
        #1 reset = 1'b1;
        #1;
        checkBit("async_rd_en", imem_rd_en, 1'b0);
        doReset();
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 1, 32'h22);
        applyStimulus(1, 1, 0, 0);
        checkBit("pre_reset_fault", fault, 1'b1);
        #1 reset = 1'b1;
        #1;
        checkBit("async_fault_clear", fault, 1'b0);

        // Randomized traffic against the expected instruction stream
        doReset();
        exp_pc    = 32'h0;
        pops      = 0;
        prev_hold = 1'b0;
        prev_rv   = 1'b0;
        prev_pc   = 32'h0;
        prev_code = 32'h0;
        prev_rpc  = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            en  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0, 1:    rpc = 32'($urandom_range(0, 10)) << 2;
                2:       rpc = (32'($urandom_range(0, 10)) << 2) + 32'($urandom_range(1, 3));
                default: rpc = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC
                                                           : 32'h2C + (32'($urandom_range(0, 4)) << 2);
            endcase
            applyStimulus(en, rdy, rv, rpc);

            if (prev_hold) begin
                checkBit("rand_hold_valid", inst_valid, 1'b1);
                checkOutput("rand_hold_pc", inst_pc, prev_pc);
                checkOutput("rand_hold_code", inst_code, prev_code);
            end
            if (prev_rv) checkBit("rand_redirect_fault", fault, !legal_pc(prev_rpc));
            checkBit("rand_issue_rule", imem_rd_en && (rv || !en || !legal_pc(imem_addr)), 1'b0);

            if (rv) begin
                exp_pc = rpc;
            end else if (inst_valid && rdy) begin
                checkBit("rand_pop_legal", legal_pc(inst_pc) && legal_pc(exp_pc), 1'b1);
                checkOutput("rand_pop_pc", inst_pc, exp_pc);
                checkOutput("rand_pop_code", inst_code, mem[exp_pc[5:2]]);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end

            prev_hold = inst_valid && !rdy && !rv;
            prev_pc   = inst_pc;
            prev_code = inst_code;
            prev_rv   = rv;
            prev_rpc  = rpc;
        end
        checkBit("rand_progress", pops > 50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
